pifo_drain_checker: RTL and testbench

Test-bench sink at the PIFO output, mirroring the traffic generator on the PIFO input. During a drain phase it issues pops at an LFSR-gated rate, keeping at most one pop outstanding. It checks every dequeued packet for non-decreasing priority and counts received packets against an expected total. It also accumulates an XOR signature of packet pointers so the bench can compare it against the generator side.

---
 rtl/pifo_drain_checker.sv | 174 +++++++++++++++++
 tb/tb_pifo_drain_checker.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_drain_checker.sv
// PIFO output sink: LFSR-gated pops (one outstanding), priority-order check, count and pointer signature.
// Latency: o__pop is combinational from state/LFSR/inputs; status outputs update one cycle after the response.
// Backpressure: never stalls the PIFO; pops are withheld while empty, rate-gated, or a response is pending.
module pifo_drain_checker #(
    parameter int                   PRIO_BITS = 16,
    parameter int                   PTR_BITS  = 16,
    parameter int                   CNT_BITS  = 32,
    parameter int                   RATE_BITS = 8,
    parameter logic [RATE_BITS-1:0] LFSR_SEED = RATE_BITS'(8'hA5),
    parameter int                   TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i__drain_phase,
    input  logic [CNT_BITS-1:0]  i__expected_pkts,
    input  logic [RATE_BITS-1:0] i__drain_rate,
    input  logic                 i__pifo_empty,
    input  logic                 i__pifo_valid,
    input  logic [PTR_BITS-1:0]  i__pkt_pointer,
    input  logic [PRIO_BITS-1:0] i__pkt_priority,
    output logic                 o__pop,
    output logic                 o__done,
    output logic                 o__timeout,
    output logic [CNT_BITS-1:0]  o__pkts_received,
    output logic [15:0]          o__error_count,
    output logic [PTR_BITS-1:0]  o__ptr_signature
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    // Maximal-length feedback taps (bit n-1 set for tap n), left-shifting Fibonacci form.
    localparam int TAPS_INT =
        (RATE_BITS == 4)  ? 'h000C : (RATE_BITS == 5)  ? 'h0014 :
        (RATE_BITS == 6)  ? 'h0030 : (RATE_BITS == 7)  ? 'h0060 :
        (RATE_BITS == 9)  ? 'h0110 : (RATE_BITS == 10) ? 'h0240 :
        (RATE_BITS == 11) ? 'h0500 : (RATE_BITS == 12) ? 'h0E08 :
        (RATE_BITS == 13) ? 'h1C80 : (RATE_BITS == 14) ? 'h3802 :
        (RATE_BITS == 15) ? 'h6000 : (RATE_BITS == 16) ? 'hD008 : 'h00B8;
    localparam logic [RATE_BITS-1:0] LFSR_TAPS = RATE_BITS'(TAPS_INT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_WAIT_RESP,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [RATE_BITS-1:0] r_lfsr;
    logic [CNT_BITS-1:0]  r_expected;
    logic [CNT_BITS-1:0]  r_pkts;
    logic [PTR_BITS-1:0]  r_sig;
    logic [PRIO_BITS-1:0] r_last_prio;
    logic                 r_last_prio_vld;
    logic                 r_timeout;
    logic [15:0]          r_err_cnt;
    logic [TW-1:0]        r_timer;

    logic                 w_pop;
    logic                 w_start;
    logic                 w_accept;
    logic                 w_tmo;
    logic                 w_err_inc;
    logic                 w_lfsr_fb;
    logic [CNT_BITS-1:0]  w_pkts_inc;

    assign w_pkts_inc = r_pkts + CNT_BITS'(1);
    assign w_lfsr_fb  = ^(r_lfsr & LFSR_TAPS);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_tmo       = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_err_inc = i__pifo_valid;
                if (i__drain_phase) begin
                    w_start     = 1'b1;
                    w_state_nxt = (i__expected_pkts == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A valid here, even alongside our own pop, cannot be a response yet.
                w_err_inc = i__pifo_valid;
                if (!i__drain_phase) begin
                    w_state_nxt = S_IDLE;
                end else if (!i__pifo_empty && (r_lfsr < i__drain_rate)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (i__pifo_valid) begin
                    w_accept  = 1'b1;
                    w_err_inc = r_last_prio_vld && (i__pkt_priority < r_last_prio);
                    if (w_pkts_inc == r_expected) begin
                        w_state_nxt = S_DONE;
                    end else if (!i__drain_phase) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_err_inc = i__pifo_valid;
                if (!i__drain_phase) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_lfsr          <= LFSR_SEED;
            r_expected      <= '0;
            r_pkts          <= '0;
            r_sig           <= '0;
            r_last_prio     <= '0;
            r_last_prio_vld <= 1'b0;
            r_timeout       <= 1'b0;
            r_err_cnt       <= '0;
            r_timer         <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DRAIN) begin
                r_lfsr <= {r_lfsr[RATE_BITS-2:0], w_lfsr_fb};
            end
            if (w_start) begin
                r_expected      <= i__expected_pkts;
                r_pkts          <= '0;
                r_sig           <= '0;
                r_last_prio_vld <= 1'b0;
                r_timeout       <= 1'b0;
            end
            if (w_pop) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT_RESP) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_accept) begin
                r_pkts          <= w_pkts_inc;
                r_sig           <= r_sig ^ i__pkt_pointer;
                r_last_prio     <= i__pkt_priority;
                r_last_prio_vld <= 1'b1;
            end
            if (w_tmo) begin
                r_timeout <= 1'b1;
            end
            if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o__pop           = w_pop;
    assign o__done          = (r_state == S_DONE);
    assign o__timeout       = r_timeout;
    assign o__pkts_received = r_pkts;
    assign o__error_count   = r_err_cnt;
    assign o__ptr_signature = r_sig;

endmodule

// File: tb/tb_pifo_drain_checker.sv
// Bench for pifo_drain_checker: behavioural PIFO model feeding a scoreboard of per-phase expected results.
module tb_pifo_drain_checker;

    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [15:0] prio;
        logic [15:0] ptr;
    } ent_t;

    typedef struct packed {
        logic [31:0] pkts;
        logic [15:0] errs;
        logic [15:0] sig;
        logic        tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        drain_phase;
    logic [31:0] expected_pkts;
    logic [7:0]  drain_rate;
    logic        pifo_empty;
    logic        pifo_valid;
    logic [15:0] pkt_pointer;
    logic [15:0] pkt_priority;
    logic        o_pop;
    logic        o_done;
    logic        o_timeout;
    logic [31:0] o_pkts;
    logic [15:0] o_errs;
    logic [15:0] o_sig;

    int   errors = 0;
    int   checks = 0;
    ent_t m_q[$];
    exp_t exp_q[$];
    ent_t pend_e;
    logic pend;
    int   pend_cd;
    int   resp_delay;
    logic spur_req;
    logic popped;
    logic done_s;
    logic to_s;
    int   pops_seen;

    always #5 clk = ~clk;

    pifo_drain_checker dut (
        .clk              (clk),
        .reset            (rst_n),
        .i__drain_phase   (drain_phase),
        .i__expected_pkts (expected_pkts),
        .i__drain_rate    (drain_rate),
        .i__pifo_empty    (pifo_empty),
        .i__pifo_valid    (pifo_valid),
        .i__pkt_pointer   (pkt_pointer),
        .i__pkt_priority  (pkt_priority),
        .o__pop           (o_pop),
        .o__done          (o_done),
        .o__timeout       (o_timeout),
        .o__pkts_received (o_pkts),
        .o__error_count   (o_errs),
        .o__ptr_signature (o_sig)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: each rising o__done consumes one expected phase result.
    task automatic monitor();
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (o_done && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no completion");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_pkts", o_pkts, e.pkts);
                    chk("done_errs", 32'(o_errs), 32'(e.errs));
                    chk("done_sig", 32'(o_sig), 32'(e.sig));
                    chk("done_timeout", 32'(o_timeout), 32'(e.tmo));
                end
            end
            prev = o_done;
        end
    endtask

    // Inserts after equal priorities unless raw order is requested.
    task automatic load(input logic [15:0] prio, input logic [15:0] ptr, input logic sorted);
        ent_t e;
        int   idx;
        e.prio = prio;
        e.ptr  = ptr;
        idx    = m_q.size();
        if (sorted) begin
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (m_q[i].prio > prio) idx = i;
            end
        end
        m_q.insert(idx, e);
        pifo_empty = (m_q.size() == 0);
    endtask

    task automatic push_exp(input int pkts, input int errs, input logic [15:0] sig, input logic tmo);
        exp_t e;
        e.pkts = 32'(pkts);
        e.errs = 16'(errs);
        e.sig  = sig;
        e.tmo  = tmo;
        exp_q.push_back(e);
    endtask

    // One clock: sample outputs at negedge, then update the PIFO model just after posedge.
    task automatic cycle();
        @(negedge clk);
        popped = o_pop;
        done_s = o_done;
        to_s   = o_timeout;
        if (o_pop) begin
            pops_seen++;
            if (m_q.size() > 0) begin
                pend_e = m_q.pop_front();
                if (resp_delay > 0) begin
                    pend    = 1'b1;
                    pend_cd = resp_delay;
                end
            end
        end
        @(posedge clk);
        #1;
        pifo_valid = 1'b0;
        if (pend) begin
            if (pend_cd == 1) begin
                pifo_valid   = 1'b1;
                pkt_pointer  = pend_e.ptr;
                pkt_priority = pend_e.prio;
                pend         = 1'b0;
            end else begin
                pend_cd--;
            end
        end else if (spur_req) begin
            pifo_valid   = 1'b1;
            pkt_pointer  = 16'hDEAD;
            pkt_priority = 16'h0000;
            spur_req     = 1'b0;
        end
        pifo_empty = (m_q.size() == 0);
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        done_s = 1'b0;
        while (!done_s && n < limit) begin
            cycle();
            n++;
        end
        if (!done_s) chk(name, 32'(done_s), 32'd1);
    endtask

    task automatic wait_pop(input string name, input int limit);
        int n;
        n = 0;
        popped = 1'b0;
        while (!popped && n < limit) begin
            cycle();
            n++;
        end
        if (!popped) chk(name, 32'(popped), 32'd1);
    endtask

    task automatic end_phase();
        drain_phase = 1'b0;
        repeat (3) cycle();
    endtask

    initial begin
        int k;
        rst_n         = 1'b0;
        drain_phase   = 1'b0;
        expected_pkts = '0;
        drain_rate    = 8'hFF;
        pifo_empty    = 1'b1;
        pifo_valid    = 1'b0;
        pkt_pointer   = '0;
        pkt_priority  = '0;
        pend          = 1'b0;
        pend_cd       = 0;
        pend_e        = '0;
        resp_delay    = 1;
        spur_req      = 1'b0;
        popped        = 1'b0;
        done_s        = 1'b0;
        to_s          = 1'b0;
        pops_seen     = 0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pop", 32'(o_pop), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        chk("rst_pkts", o_pkts, 0);
        chk("rst_errs", 32'(o_errs), 0);
        chk("rst_sig", 32'(o_sig), 0);
        rst_n = 1'b1;
        cycle();

        // Priorities 5,3,9,3 drain as 3,3,5,9; signature 1111^2222^3333^4444.
        load(16'd5, 16'h1111, 1'b1);
        load(16'd3, 16'h2222, 1'b1);
        load(16'd9, 16'h3333, 1'b1);
        load(16'd3, 16'h4444, 1'b1);
        push_exp(4, 0, 16'h4444, 1'b0);
        expected_pkts = 32'd4;
        drain_rate    = 8'hFF;
        drain_phase   = 1'b1;
        wait_done("t1_done_wait", 300);
        end_phase();

        // Out-of-order model: 4 then 2 gives one order violation.
        load(16'd4, 16'h00A0, 1'b0);
        load(16'd2, 16'h000B, 1'b0);
        push_exp(2, 1, 16'h00AB, 1'b0);
        expected_pkts = 32'd2;
        drain_phase   = 1'b1;
        wait_done("t2_done_wait", 300);
        end_phase();

        // Rate 0 never pops; then full rate finishes the phase.
        load(16'd1, 16'h0010, 1'b1);
        load(16'd2, 16'h0020, 1'b1);
        load(16'd3, 16'h0040, 1'b1);
        push_exp(3, 1, 16'h0070, 1'b0);
        expected_pkts = 32'd3;
        drain_rate    = 8'h00;
        drain_phase   = 1'b1;
        pops_seen     = 0;
        repeat (100) cycle();
        chk("rate0_pops", 32'(pops_seen), 0);
        chk("rate0_done", 32'(done_s), 0);
        drain_rate = 8'hFF;
        wait_done("t3_done_wait", 300);
        end_phase();

        // No response: timer decides in the 64th wait cycle, flag visible one cycle later.
        resp_delay = 0;
        load(16'd7, 16'h0999, 1'b1);
        push_exp(0, 2, 16'h0000, 1'b1);
        expected_pkts = 32'd1;
        drain_phase   = 1'b1;
        wait_pop("t4_pop_wait", 100);
        k = 0;
        for (int i = 1; i <= 200 && k == 0; i++) begin
            cycle();
            if (to_s) k = i;
        end
        chk("timeout_latency", 32'(k), 32'(TIMEOUT + 1));
        end_phase();
        resp_delay = 1;

        // Phase drops while waiting; the late response is still accepted, then IDLE.
        resp_delay = 2;
        load(16'd7, 16'h0005, 1'b1);
        load(16'd8, 16'h0006, 1'b1);
        expected_pkts = 32'd2;
        drain_phase   = 1'b1;
        wait_pop("t5_pop_wait", 100);
        drain_phase = 1'b0;
        repeat (4) cycle();
        chk("abort_pkts", o_pkts, 1);
        chk("abort_sig", 32'(o_sig), 32'h0005);
        chk("abort_done", 32'(done_s), 0);
        chk("abort_errs", 32'(o_errs), 2);
        m_q.delete();
        pifo_empty = 1'b1;
        spur_req   = 1'b1;
        repeat (3) cycle();
        chk("spurious_idle_errs", 32'(o_errs), 3);

        // Asynchronous reset while a response is outstanding.
        resp_delay = 3;
        load(16'd1, 16'h0077, 1'b1);
        expected_pkts = 32'd1;
        drain_phase   = 1'b1;
        wait_pop("t6_pop_wait", 100);
        #2;
        rst_n       = 1'b0;
        drain_phase = 1'b0;
        #1;
        chk("midrst_pop", 32'(o_pop), 0);
        chk("midrst_done", 32'(o_done), 0);
        chk("midrst_timeout", 32'(o_timeout), 0);
        chk("midrst_pkts", o_pkts, 0);
        chk("midrst_errs", 32'(o_errs), 0);
        chk("midrst_sig", 32'(o_sig), 0);
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("late_resp_errs", 32'(o_errs), 1);
        chk("late_resp_pkts", o_pkts, 0);

        resp_delay = 1;
        load(16'h0100, 16'hBEEF, 1'b1);
        push_exp(1, 1, 16'hBEEF, 1'b0);
        expected_pkts = 32'd1;
        drain_phase   = 1'b1;
        wait_done("t7_done_wait", 300);
        end_phase();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
